// File: rtl/dme_status_monitor_pkg.sv
// Shared definitions for the DME status monitor: FSM encoding, ID sentinel,
// default timing parameters and the reset-release qualifier.
package dme_pkg;

  localparam int DEB_CYCLES_DEF = 32;
  localparam int RST_DLY_DEF    = 1024;

  localparam logic [3:0] DME_ID_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_ABSENT   = 2'd0,
    ST_WAIT_PWR = 2'd1,
    ST_RST_HOLD = 2'd2,
    ST_RUN      = 2'd3
  } dme_state_e;

  // The DME may leave reset only while it is powered and the platform is out of reset.
  function automatic logic release_ok(input logic pwrgd, input logic pltrst_n);
    return pwrgd & pltrst_n;
  endfunction

endpackage

// File: rtl/dme_status_monitor_if.sv
// Pin-level bundle between the platform/DME side and the status monitor.
interface dme_status_monitor_if;
  logic       RST_PLTRST_N;
  logic       DME_PWRGD;
  logic       DME_Absent;
  logic [3:0] DMEID;
  logic [5:0] DMEStatus;
  logic       StatusChgClr;
  logic       RST_DME_N;
  logic       DMEPresent;
  logic [3:0] DMEIDLatched;
  logic [5:0] DMEStatusReg;
  logic       DMEStatusChg;
  logic [1:0] DMEState;

  // Platform / DME / BMC side: drives the pins, observes the monitor outputs.
  modport master (
    output RST_PLTRST_N, DME_PWRGD, DME_Absent, DMEID, DMEStatus, StatusChgClr,
    input  RST_DME_N, DMEPresent, DMEIDLatched, DMEStatusReg, DMEStatusChg, DMEState
  );

  // Monitor side.
  modport slave (
    input  RST_PLTRST_N, DME_PWRGD, DME_Absent, DMEID, DMEStatus, StatusChgClr,
    output RST_DME_N, DMEPresent, DMEIDLatched, DMEStatusReg, DMEStatusChg, DMEState
  );
endinterface

// File: rtl/dme_status_monitor_debounce.sv
// Two-flop synchroniser followed by a stability filter. The output takes a
// new value only after DEB_CYCLES consecutive identical synchronised samples;
// a vector input is filtered as a whole, so any bit change restarts the count.
module dme_debounce #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] last;
  logic [CW-1:0]    cnt;

  // Bring the asynchronous pins into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= {WIDTH{1'b0}};
      sync <= {WIDTH{1'b0}};
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Count identical samples (saturating) and commit the value once stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= {WIDTH{1'b0}};
      cnt  <= {CW{1'b0}};
      dout <= {WIDTH{1'b0}};
    end else if (sync != last) begin
      last <= sync;
      cnt  <= CNT_ONE;
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
      if (cnt >= CNT_LAST) begin
        dout <= sync;
      end else begin
        dout <= dout;
      end
    end
  end

endmodule

// File: rtl/dme_status_monitor.sv
// DME-side reset sequencer: qualifies presence, power-good, platform reset
// and status pins, latches the board ID and releases RST_DME_N only after the
// DME has been present, powered and out of platform reset for RST_DLY cycles.
module dme_status_monitor
  import dme_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RST_DLY    = RST_DLY_DEF
) (
  input logic                 SysClk,
  input logic                 SysReset,
  dme_status_monitor_if.slave bus
);

  localparam int            DW       = $clog2(RST_DLY + 1);
  localparam logic [DW-1:0] DLY_INIT = DW'(RST_DLY - 1);
  localparam logic [DW-1:0] DLY_ONE  = DW'(1);
  localparam logic [DW-1:0] DLY_ZERO = DW'(0);

  logic       present_deb;
  logic       pwrgd_deb;
  logic [5:0] status_deb;
  logic [4:0] plt_id_meta;
  logic [4:0] plt_id_sync;
  logic       pltrst_sync;
  logic [3:0] id_sync;

  dme_state_e    state;
  logic          rst_dme_n;
  logic [3:0]    id_latched;
  logic [DW-1:0] dly_cnt;
  logic [5:0]    status_reg;
  logic          status_chg;

  dme_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_present (
    .clk(SysClk), .rst(SysReset), .din(~bus.DME_Absent), .dout(present_deb)
  );

  dme_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_pwrgd (
    .clk(SysClk), .rst(SysReset), .din(bus.DME_PWRGD), .dout(pwrgd_deb)
  );

  dme_debounce #(.WIDTH(6), .DEB_CYCLES(DEB_CYCLES)) u_deb_status (
    .clk(SysClk), .rst(SysReset), .din(bus.DMEStatus), .dout(status_deb)
  );

  // Platform reset and ID straps are synchronised but not filtered.
  always_ff @(posedge SysClk or posedge SysReset) begin
    if (SysReset) begin
      plt_id_meta <= 5'd0;
      plt_id_sync <= 5'd0;
    end else begin
      plt_id_meta <= {bus.RST_PLTRST_N, bus.DMEID};
      plt_id_sync <= plt_id_meta;
    end
  end

  assign pltrst_sync = plt_id_sync[4];
  assign id_sync     = plt_id_sync[3:0];

  // Sequencing FSM with registered reset output, ID latch, delay counter and status tracking.
  always_ff @(posedge SysClk or posedge SysReset) begin
    if (SysReset) begin
      state      <= ST_ABSENT;
      rst_dme_n  <= 1'b0;
      id_latched <= DME_ID_NONE;
      dly_cnt    <= DLY_ZERO;
      status_reg <= 6'd0;
      status_chg <= 1'b0;
    end else begin
      // Release follows RUN entry by one cycle; re-assertion follows RUN exit by one cycle.
      rst_dme_n <= (state == ST_RUN);

      // A change seen while running both updates the register and raises the
      // sticky flag; a clear arriving in the same cycle loses.
      if ((state == ST_RUN) && (status_deb != status_reg)) begin
        status_chg <= 1'b1;
        status_reg <= status_deb;
      end else if (bus.StatusChgClr) begin
        status_chg <= 1'b0;
      end else begin
        status_chg <= status_chg;
      end

      if (!present_deb) begin
        state      <= ST_ABSENT;
        id_latched <= DME_ID_NONE;
      end else begin
        case (state)
          ST_ABSENT: begin
            state <= ST_WAIT_PWR;
          end
          ST_WAIT_PWR: begin
            if (release_ok(pwrgd_deb, pltrst_sync)) begin
              state      <= ST_RST_HOLD;
              id_latched <= id_sync;
              dly_cnt    <= DLY_INIT;
            end else begin
              state <= ST_WAIT_PWR;
            end
          end
          ST_RST_HOLD: begin
            if (!release_ok(pwrgd_deb, pltrst_sync)) begin
              state <= ST_WAIT_PWR;
            end else if (dly_cnt == DLY_ZERO) begin
              // Entry snapshot of the status is not treated as a change.
              state      <= ST_RUN;
              status_reg <= status_deb;
            end else begin
              dly_cnt <= dly_cnt - DLY_ONE;
            end
          end
          ST_RUN: begin
            if (!release_ok(pwrgd_deb, pltrst_sync)) begin
              state <= ST_WAIT_PWR;
            end else begin
              state <= ST_RUN;
            end
          end
          default: begin
            state <= ST_ABSENT;
          end
        endcase
      end
    end
  end

  assign bus.RST_DME_N    = rst_dme_n;
  assign bus.DMEPresent   = present_deb;
  assign bus.DMEIDLatched = id_latched;
  assign bus.DMEStatusReg = status_reg;
  assign bus.DMEStatusChg = status_chg;
  assign bus.DMEState     = state;

endmodule

// File: tb/tb_dme_status_monitor.sv
// Self-checking bench for dme_status_monitor with DEB_CYCLES=4, RST_DLY=8.
// A cycle-level reference model (sliding sample windows for the synchroniser
// and filter, plain sequencing rules for the FSM) is compared every cycle,
// alongside directed checks for the bring-up, glitch, removal, platform
// reset, status-change and mid-run reset scenarios.
module tb_dme_status_monitor;

  localparam int DEB = 4;
  localparam int DLY = 8;
  localparam int SH  = DEB + 2;

  logic SysClk;
  logic SysReset;

  dme_status_monitor_if bus();

  dme_status_monitor #(.DEB_CYCLES(DEB), .RST_DLY(DLY)) dut (
    .SysClk  (SysClk),
    .SysReset(SysReset),
    .bus     (bus.slave)
  );

  initial begin
    SysClk = 1'b0;
    forever #5 SysClk = ~SysClk;
  end

  int vectors;
  int miscompares;

  // Reference model state
  int         m_state;
  int         m_dly;
  logic       m_rst;
  logic [3:0] m_id;
  logic [5:0] m_sreg;
  logic       m_chg;
  logic       m_pres;
  logic       m_pwr;
  logic [5:0] m_stat;
  logic       sh_pres [SH];
  logic       sh_pwr  [SH];
  logic [5:0] sh_stat [SH];
  logic       sh_plt  [3];
  logic [3:0] sh_id   [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_dly = 0; m_rst = 1'b0; m_id = 4'hF;
    m_sreg = 6'd0; m_chg = 1'b0; m_pres = 1'b0; m_pwr = 1'b0; m_stat = 6'd0;
    for (int i = 0; i < SH; i++) begin
      sh_pres[i] = 1'b0; sh_pwr[i] = 1'b0; sh_stat[i] = 6'd0;
    end
    for (int i = 0; i < 3; i++) begin
      sh_plt[i] = 1'b0; sh_id[i] = 4'd0;
    end
  endtask

  // One clock edge of the reference behaviour, given the pin values before the edge.
  task automatic model_step(input logic absent, input logic pwr, input logic plt,
                            input logic [3:0] id, input logic [5:0] st, input logic clr);
    logic ok;
    logic same_p, same_w, same_s;
    for (int i = SH - 1; i > 0; i--) begin
      sh_pres[i] = sh_pres[i-1]; sh_pwr[i] = sh_pwr[i-1]; sh_stat[i] = sh_stat[i-1];
    end
    sh_pres[0] = ~absent; sh_pwr[0] = pwr; sh_stat[0] = st;
    for (int i = 2; i > 0; i--) begin
      sh_plt[i] = sh_plt[i-1]; sh_id[i] = sh_id[i-1];
    end
    sh_plt[0] = plt; sh_id[0] = id;

    ok = m_pwr & sh_plt[2];
    m_rst = (m_state == 3);
    if (m_state == 3 && m_stat != m_sreg) begin
      m_chg = 1'b1; m_sreg = m_stat;
    end else if (clr) begin
      m_chg = 1'b0;
    end
    if (!m_pres) begin
      m_state = 0; m_id = 4'hF;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (ok) begin m_state = 2; m_id = sh_id[2]; m_dly = DLY - 1; end
    end else if (m_state == 2) begin
      if (!ok) m_state = 1;
      else if (m_dly == 0) begin m_state = 3; m_sreg = m_stat; end
      else m_dly = m_dly - 1;
    end else begin
      if (!ok) m_state = 1;
    end

    // A filtered value follows the synced samples once the last DEB of them agree.
    same_p = 1'b1; same_w = 1'b1; same_s = 1'b1;
    for (int i = 3; i < SH; i++) begin
      if (sh_pres[i] !== sh_pres[2]) same_p = 1'b0;
      if (sh_pwr[i]  !== sh_pwr[2])  same_w = 1'b0;
      if (sh_stat[i] !== sh_stat[2]) same_s = 1'b0;
    end
    if (same_p) m_pres = sh_pres[2];
    if (same_w) m_pwr  = sh_pwr[2];
    if (same_s) m_stat = sh_stat[2];
  endtask

  task automatic compare_all();
    check("RST_DME_N",    32'(bus.RST_DME_N),    32'(m_rst));
    check("DMEPresent",   32'(bus.DMEPresent),   32'(m_pres));
    check("DMEIDLatched", 32'(bus.DMEIDLatched), 32'(m_id));
    check("DMEStatusReg", 32'(bus.DMEStatusReg), 32'(m_sreg));
    check("DMEStatusChg", 32'(bus.DMEStatusChg), 32'(m_chg));
    check("DMEState",     32'(bus.DMEState),     m_state);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_rst_dme_n"}, 32'(bus.RST_DME_N),    32'd0);
    check({tag, "_present"},   32'(bus.DMEPresent),   32'd0);
    check({tag, "_id"},        32'(bus.DMEIDLatched), 32'hF);
    check({tag, "_sreg"},      32'(bus.DMEStatusReg), 32'd0);
    check({tag, "_chg"},       32'(bus.DMEStatusChg), 32'd0);
    check({tag, "_state"},     32'(bus.DMEState),     32'd0);
  endtask

  task automatic tick();
    logic a, pw, pl, clr;
    logic [3:0] id;
    logic [5:0] st;
    a = bus.DME_Absent; pw = bus.DME_PWRGD; pl = bus.RST_PLTRST_N;
    id = bus.DMEID; st = bus.DMEStatus; clr = bus.StatusChgClr;
    @(posedge SysClk);
    if (SysReset) model_reset();
    else model_step(a, pw, pl, id, st, clr);
    #1;
    compare_all();
  endtask

  task automatic wait_state(input string tag, input int target, input int budget, output int n);
    n = 0;
    while (32'(bus.DMEState) != target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.DMEState), target);
  endtask

  task automatic bring_up(input string tag);
    int n;
    wait_state({tag, "_wait_pwr"}, 1, 20, n);
    wait_state({tag, "_rst_hold"}, 2, 20, n);
    wait_state({tag, "_run"}, 3, 20, n);
    check({tag, "_hold_len"}, n, DLY);
    check({tag, "_rst_low_at_run"}, 32'(bus.RST_DME_N), 32'd0);
    tick();
    check({tag, "_rst_release"}, 32'(bus.RST_DME_N), 32'd1);
  endtask

  initial begin
    int n;
    int len;
    logic [3:0] nid;
    logic [5:0] v;
    vectors = 0;
    miscompares = 0;

    SysReset = 1'b1;
    bus.DME_Absent = 1'b1; bus.DME_PWRGD = 1'b0; bus.RST_PLTRST_N = 1'b0;
    bus.DMEID = 4'h0; bus.DMEStatus = 6'h00; bus.StatusChgClr = 1'b0;
    model_reset();
    #1;
    reset_vals("reset");
    tick(); tick();
    SysReset = 1'b0;

    // 1. Nominal bring-up
    bus.DME_Absent = 1'b0; bus.DMEID = 4'h5; bus.DME_PWRGD = 1'b1; bus.RST_PLTRST_N = 1'b1;
    bring_up("t1");
    check("t1_id", 32'(bus.DMEIDLatched), 32'h5);
    check("t1_present", 32'(bus.DMEPresent), 32'd1);

    // 2. Short power-good glitch is filtered, long one drops to WAIT_PWR
    len = $urandom_range(3, 1);
    bus.DME_PWRGD = 1'b0;
    repeat (len) tick();
    bus.DME_PWRGD = 1'b1;
    repeat (12) begin
      tick();
      check("t2_glitch_state", 32'(bus.DMEState), 32'd3);
      check("t2_glitch_rst", 32'(bus.RST_DME_N), 32'd1);
    end
    bus.DME_PWRGD = 1'b0;
    repeat (10) tick();
    check("t2_long_state", 32'(bus.DMEState), 32'd1);
    check("t2_long_rst", 32'(bus.RST_DME_N), 32'd0);
    bus.DME_PWRGD = 1'b1;
    wait_state("t2_hold", 2, 20, n);
    wait_state("t2_run", 3, 20, n);
    check("t2_hold_len", n, DLY);
    tick();

    // 4. Platform reset in the middle of the hold restarts the delay
    bus.RST_PLTRST_N = 1'b0;
    wait_state("t4_drop", 1, 10, n);
    bus.RST_PLTRST_N = 1'b1;
    wait_state("t4_hold", 2, 10, n);
    repeat (3) tick();
    bus.RST_PLTRST_N = 1'b0;
    wait_state("t4_abort", 1, 10, n);
    check("t4_rst_low", 32'(bus.RST_DME_N), 32'd0);
    bus.RST_PLTRST_N = 1'b1;
    wait_state("t4_rehold", 2, 10, n);
    wait_state("t4_run", 3, 20, n);
    check("t4_hold_len", n, DLY);
    tick();

    // 3. Hot removal, then reinsertion with a different ID
    bus.DME_Absent = 1'b1;
    wait_state("t3_absent", 0, 20, n);
    check("t3_latency_ok", 32'((n >= 5) && (n <= 8)), 32'd1);
    check("t3_id_none", 32'(bus.DMEIDLatched), 32'hF);
    check("t3_present", 32'(bus.DMEPresent), 32'd0);
    tick();
    check("t3_rst", 32'(bus.RST_DME_N), 32'd0);
    nid = 4'($urandom_range(14, 0));
    bus.DMEID = nid;
    bus.DME_Absent = 1'b0;
    bring_up("t3b");
    check("t3b_id", 32'(bus.DMEIDLatched), 32'(nid));

    // 5. Status change sets the sticky flag; set wins over a simultaneous clear
    bus.DMEStatus = 6'h2A;
    n = 0;
    while (bus.DMEStatusChg !== 1'b1 && n < 15) begin tick(); n++; end
    check("t5_chg_set", 32'(bus.DMEStatusChg), 32'd1);
    check("t5_latency_ok", 32'((n >= 5) && (n <= 8)), 32'd1);
    check("t5_sreg", 32'(bus.DMEStatusReg), 32'h2A);
    bus.StatusChgClr = 1'b1; tick(); bus.StatusChgClr = 1'b0;
    check("t5_clr", 32'(bus.DMEStatusChg), 32'd0);
    repeat (4) begin
      v = 6'($urandom_range(63, 0));
      if (v == bus.DMEStatus) v = v ^ 6'h15;
      bus.DMEStatus = v;
      n = 0;
      while (!(m_state == 3 && m_stat != m_sreg) && n < 15) begin tick(); n++; end
      bus.StatusChgClr = 1'b1; tick(); bus.StatusChgClr = 1'b0;
      check("t5_set_beats_clr", 32'(bus.DMEStatusChg), 32'd1);
      check("t5_sreg_track", 32'(bus.DMEStatusReg), 32'(v));
      bus.StatusChgClr = 1'b1; tick(); bus.StatusChgClr = 1'b0;
      check("t5_clr_again", 32'(bus.DMEStatusChg), 32'd0);
    end

    // 6. Asynchronous reset while running
    #2;
    SysReset = 1'b1;
    model_reset();
    #1;
    reset_vals("t6");
    tick(); tick();
    SysReset = 1'b0;
    bring_up("t6");
    check("t6_id", 32'(bus.DMEIDLatched), 32'(nid));

    // Random soak against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(39, 0) == 0) bus.DME_Absent = ~bus.DME_Absent;
      if ($urandom_range(14, 0) == 0) bus.DME_PWRGD = ~bus.DME_PWRGD;
      if ($urandom_range(24, 0) == 0) bus.RST_PLTRST_N = ~bus.RST_PLTRST_N;
      if ($urandom_range(7, 0) == 0) bus.DMEStatus = 6'($urandom_range(63, 0));
      if ($urandom_range(9, 0) == 0) bus.DMEID = 4'($urandom_range(15, 0));
      bus.StatusChgClr = ($urandom_range(9, 0) == 0);
      tick();
    end
    bus.StatusChgClr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
